// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the instruction/data memory port arbiter.
// Arbiter state values and the grant-owner tag used by the top and its helpers.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_IF_WAIT = 2'd1,
        ARB_D_WAIT  = 2'd2,
        ARB_RESP    = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWNER_IF = 1'b0,
        OWNER_D  = 1'b1
    } owner_t;

endpackage

// File: rtl/mem_port_arbiter_starve_ctr.sv
// Fetch starvation guard for mem_port_arbiter, built only with MEM_ARB_STARVE_GUARD_EN.
// Counts data grants taken while fetch waits; o_starved forces the next fetch grant.
`ifdef MEM_ARB_STARVE_GUARD_EN
module mem_arb_starve_ctr
    import mem_port_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_ifReq,
    input  logic i_dGrant,
    input  logic i_ifGrant,
    output logic o_starved
);

    localparam int CW = $clog2(STARVE_MAX + 1);

    logic [CW-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_ifGrant) begin
            r_count <= '0;
        end else if (i_dGrant && i_ifReq && (r_count != CW'(STARVE_MAX))) begin
            r_count <= r_count + CW'(1);
        end
    end

    assign o_starved = (r_count == CW'(STARVE_MAX));

endmodule
`endif

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory bus between fetch and load/store, data first.
// Optional fetch starvation guard: define MEM_ARB_STARVE_GUARD_EN.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_ifReq,
    input  logic [XLEN-1:0] i_ifAddr,
    output logic            o_ifValid,
    output logic [XLEN-1:0] o_ifData,
    input  logic            i_dReq,
    input  logic            i_dWe,
    input  logic [XLEN-1:0] i_dAddr,
    input  logic [XLEN-1:0] i_dWData,
    output logic            o_dValid,
    output logic [XLEN-1:0] o_dRData,
    output logic            o_busReq,
    output logic            o_busWe,
    output logic [XLEN-1:0] o_busAddr,
    output logic [XLEN-1:0] o_busWData,
    input  logic            i_busAck,
    input  logic [XLEN-1:0] i_busRData,
    output logic [1:0]      o_dbgState
);

    arb_state_t      r_state;
    arb_state_t      w_next;
    owner_t          r_owner;
    logic            r_stale;
    logic            r_busReq;
    logic            r_busWe;
    logic [XLEN-1:0] r_busAddr;
    logic [XLEN-1:0] r_busWData;
    logic [XLEN-1:0] r_ifData;
    logic [XLEN-1:0] r_dRData;
    logic            w_dGrant;
    logic            w_ifGrant;
    logic            w_override;
    logic            w_ack;

    // Acks are only meaningful while a transaction is actually on the bus.
    assign w_ack = i_busAck && ((r_state == ARB_IF_WAIT) || (r_state == ARB_D_WAIT));

`ifdef MEM_ARB_STARVE_GUARD_EN
    logic w_starved;

    mem_arb_starve_ctr #(.STARVE_MAX(STARVE_MAX)) u_starve_ctr (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_ifReq   (i_ifReq),
        .i_dGrant  (w_dGrant),
        .i_ifGrant (w_ifGrant),
        .o_starved (w_starved)
    );

    assign w_override = w_starved && i_ifReq && i_dReq;
`else
    assign w_override = 1'b0;
`endif

    assign w_dGrant  = (r_state == ARB_IDLE) && i_dReq && !w_override;
    assign w_ifGrant = (r_state == ARB_IDLE) && i_ifReq && !w_dGrant;

    always_comb begin
        w_next = r_state;
        case (r_state)
            ARB_IDLE: begin
                if (w_dGrant) begin
                    w_next = ARB_D_WAIT;
                end else if (w_ifGrant) begin
                    w_next = ARB_IF_WAIT;
                end
            end
            ARB_IF_WAIT, ARB_D_WAIT: begin
                if (i_busAck) begin
                    w_next = ARB_RESP;
                end
            end
            ARB_RESP: w_next = ARB_IDLE;
            default:  w_next = ARB_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= ARB_IDLE;
            r_owner    <= OWNER_IF;
            r_stale    <= 1'b0;
            r_busReq   <= 1'b0;
            r_busWe    <= 1'b0;
            r_busAddr  <= '0;
            r_busWData <= '0;
            r_ifData   <= '0;
            r_dRData   <= '0;
        end else begin
            r_state <= w_next;
            if (w_dGrant) begin
                r_busReq   <= 1'b1;
                r_busWe    <= i_dWe;
                r_busAddr  <= i_dAddr;
                r_busWData <= i_dWData;
                r_owner    <= OWNER_D;
            end else if (w_ifGrant) begin
                r_busReq  <= 1'b1;
                r_busWe   <= 1'b0;
                r_busAddr <= i_ifAddr;
                r_owner   <= OWNER_IF;
            end
            if (w_ack) begin
                r_busReq <= 1'b0;
                if (r_owner == OWNER_IF) begin
                    r_ifData <= i_busRData;
                end else if (!r_busWe) begin
                    r_dRData <= i_busRData;
                end
            end
            // A withdrawn or redirected fetch still completes on the bus, but its word is discarded.
            if ((r_state == ARB_IF_WAIT) && (!i_ifReq || (i_ifAddr != r_busAddr))) begin
                r_stale <= 1'b1;
            end else if (r_state == ARB_RESP) begin
                r_stale <= 1'b0;
            end
        end
    end

    assign o_busReq   = r_busReq;
    assign o_busWe    = r_busWe;
    assign o_busAddr  = r_busAddr;
    assign o_busWData = r_busWData;
    assign o_ifData   = r_ifData;
    assign o_dRData   = r_dRData;
    assign o_ifValid  = (r_state == ARB_RESP) && (r_owner == OWNER_IF) && !r_stale;
    assign o_dValid   = (r_state == ARB_RESP) && (r_owner == OWNER_D);
    assign o_dbgState = r_state;

    // Handshake: a side's request is held until its one-cycle valid pulse;
    // the bus request fields stay frozen from grant until the ack cycle.
    a_dreq_held: assert property (@(posedge i_clk) disable iff (i_rst)
        (r_state == ARB_D_WAIT) |-> i_dReq);
    a_one_valid: assert property (@(posedge i_clk) disable iff (i_rst)
        !(o_ifValid && o_dValid));
    a_bus_stable: assert property (@(posedge i_clk) disable iff (i_rst)
        (r_busReq && !w_ack) |=> ($stable(r_busAddr) && $stable(r_busWe) && $stable(r_busWData)));
    a_starve_cfg: assert property (@(posedge i_clk) STARVE_MAX >= 1);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table, hand sequences for
// multi-cycle corners, and randomized traffic against a transaction-level model.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    localparam int XLEN       = 32;
    localparam int W          = XLEN + 1;
    localparam int STARVE_MAX = 4;
    localparam int TIMEOUT    = 200;

    logic            clk;
    logic            i_rst;
    logic            i_ifReq;
    logic [XLEN-1:0] i_ifAddr;
    logic            o_ifValid;
    logic [XLEN-1:0] o_ifData;
    logic            i_dReq;
    logic            i_dWe;
    logic [XLEN-1:0] i_dAddr;
    logic [XLEN-1:0] i_dWData;
    logic            o_dValid;
    logic [XLEN-1:0] o_dRData;
    logic            o_busReq;
    logic            o_busWe;
    logic [XLEN-1:0] o_busAddr;
    logic [XLEN-1:0] o_busWData;
    logic            bus_ack;
    logic [XLEN-1:0] bus_rdata;
    logic [1:0]      o_dbgState;

    mem_port_arbiter #(.XLEN(XLEN), .STARVE_MAX(STARVE_MAX)) dut (
        .i_clk      (clk),
        .i_rst      (i_rst),
        .i_ifReq    (i_ifReq),
        .i_ifAddr   (i_ifAddr),
        .o_ifValid  (o_ifValid),
        .o_ifData   (o_ifData),
        .i_dReq     (i_dReq),
        .i_dWe      (i_dWe),
        .i_dAddr    (i_dAddr),
        .i_dWData   (i_dWData),
        .o_dValid   (o_dValid),
        .o_dRData   (o_dRData),
        .o_busReq   (o_busReq),
        .o_busWe    (o_busWe),
        .o_busAddr  (o_busAddr),
        .o_busWData (o_busWData),
        .i_busAck   (bus_ack),
        .i_busRData (bus_rdata),
        .o_dbgState (o_dbgState)
    );

    // ---------------- clock / reset / bookkeeping ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // ---------------- memory model on the bus side ----------------
    logic [XLEN-1:0] bus_mem [logic [XLEN-1:0]];
    logic [XLEN-1:0] ref_mem [logic [XLEN-1:0]];
    bit mem_en  = 1'b1;
    int lat_lo  = 0;
    int lat_hi  = 0;
    int cur_lat = 0;
    int wait_cnt = 0;

    function automatic logic [XLEN-1:0] init_val(input logic [XLEN-1:0] a);
        return (a * 32'h9E3779B1) ^ 32'h0F1E2D3C;
    endfunction

    function automatic logic [XLEN-1:0] bus_rd(input logic [XLEN-1:0] a);
        return bus_mem.exists(a) ? bus_mem[a] : init_val(a);
    endfunction

    function automatic logic [XLEN-1:0] ref_rd(input logic [XLEN-1:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
    endfunction

    task automatic set_lat(input int lo, input int hi);
        lat_lo  = lo;
        lat_hi  = hi;
        cur_lat = $urandom_range(hi, lo);
    endtask

    initial begin
        bus_ack   = 1'b0;
        bus_rdata = '0;
        forever begin
            @(negedge clk);
            if (mem_en) begin
                if (bus_ack) begin
                    bus_ack  = 1'b0;
                    wait_cnt = 0;
                    cur_lat  = $urandom_range(lat_hi, lat_lo);
                end else if (o_busReq) begin
                    if (wait_cnt >= cur_lat) begin
                        bus_ack = 1'b1;
                        if (o_busWe) bus_mem[o_busAddr] = o_busWData;
                        else bus_rdata = bus_rd(o_busAddr);
                    end else begin
                        wait_cnt++;
                    end
                end else begin
                    wait_cnt = 0;
                end
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    logic [XLEN-1:0] grant_addr_q[$];
    logic            grant_we_q[$];
    logic [XLEN-1:0] grant_wd_q[$];
    logic [W-1:0]    exp_q[$];
    bit mon_en     = 1'b0;
    int if_pulses  = 0;
    int d_pulses   = 0;
    int both_high  = 0;

    initial begin
        logic            s_d, s_if, s_rst, prev_req, exp_data;
        logic [XLEN-1:0] s_da, s_ia, exp_addr;
        logic [W-1:0]    e;
        int              starve;
        prev_req = 1'b0;
        starve   = 0;
        forever begin
            @(posedge clk);
            s_d = i_dReq; s_if = i_ifReq; s_da = i_dAddr; s_ia = i_ifAddr; s_rst = i_rst;
            if (s_rst) starve = 0;
            @(negedge clk);
            if (o_busReq && !prev_req) begin
                grant_addr_q.push_back(o_busAddr);
                grant_we_q.push_back(o_busWe);
                grant_wd_q.push_back(o_busWData);
`ifdef MEM_ARB_STARVE_GUARD_EN
                exp_data = s_d && !(s_if && (starve == STARVE_MAX));
                if (exp_data && s_if) starve = (starve < STARVE_MAX) ? starve + 1 : STARVE_MAX;
                if (!exp_data) starve = 0;
`else
                exp_data = s_d;
`endif
                exp_addr = exp_data ? s_da : s_ia;
                if (mon_en) begin
                    chk("grant_addr", o_busAddr, exp_addr);
                    exp_q.push_back({exp_data, exp_addr});
                end
            end
            if (o_ifValid) if_pulses++;
            if (o_dValid) d_pulses++;
            if (o_ifValid && o_dValid) both_high++;
            if (mon_en && (o_ifValid || o_dValid)) begin
                if (exp_q.size() == 0) begin
                    chk("resp_unexpected", {o_dValid, o_ifValid}, 2'b00);
                end else begin
                    e = exp_q.pop_front();
                    chk("resp_order", o_dValid, e[W-1]);
                end
            end
            prev_req = o_busReq;
        end
    end

    // ---------------- driver tasks (called at a negedge) ----------------
    task automatic do_data(input logic we, input logic [XLEN-1:0] addr, input logic [XLEN-1:0] wd,
                           output logic [XLEN-1:0] rd, output int t_done);
        bit got = 0;
        i_dReq = 1'b1; i_dWe = we; i_dAddr = addr; i_dWData = wd;
        rd = '0; t_done = -1;
        for (int k = 0; k < TIMEOUT; k++) begin
            @(negedge clk);
            if (o_dValid) begin
                got = 1; rd = o_dRData; t_done = cyc;
                break;
            end
        end
        chk("data_done", got, 1'b1);
        i_dReq = 1'b0;
    endtask

    task automatic do_fetch(input logic [XLEN-1:0] addr, output logic [XLEN-1:0] d, output int t_done);
        bit got = 0;
        i_ifReq = 1'b1; i_ifAddr = addr;
        d = '0; t_done = -1;
        for (int k = 0; k < TIMEOUT; k++) begin
            @(negedge clk);
            if (o_ifValid) begin
                got = 1; d = o_ifData; t_done = cyc;
                break;
            end
        end
        chk("fetch_done", got, 1'b1);
        i_ifReq = 1'b0;
    endtask

    task automatic rand_data(input int n);
        logic            we;
        logic [XLEN-1:0] addr, wd, rd;
        int              t;
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(2, 0)) @(negedge clk);
            we   = 1'($urandom_range(1, 0));
            addr = 32'h1000 + 4 * $urandom_range(15, 0);
            wd   = $urandom;
            do_data(we, addr, wd, rd, t);
            if (we) ref_mem[addr] = wd;
            else chk("rand_load", rd, ref_rd(addr));
        end
    endtask

    task automatic rand_fetch(input int n);
        logic [XLEN-1:0] addr, d;
        int              t;
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(2, 0)) @(negedge clk);
            addr = 32'h400 + 4 * $urandom_range(63, 0);
            do_fetch(addr, d, t);
            chk("rand_fetch", d, init_val(addr));
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        string           name;
        bit              is_d;
        bit              we;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] wd;
        int              lat;
        bit              preload;
        logic [XLEN-1:0] mem;
        logic [XLEN-1:0] exp_rd;
    } vec_t;

    task automatic run_vec(input vec_t v);
        int              t_req, t_resp, p_if, p_d;
        logic [XLEN-1:0] a, wd, rd;
        logic            we, stable, req_at_resp;
        if (v.preload) bus_mem[v.addr] = v.mem;
        set_lat(v.lat, v.lat);
        p_if = if_pulses; p_d = d_pulses;
        t_req = -1; t_resp = -1; stable = 1'b1; req_at_resp = 1'b1;
        a = '0; wd = '0; we = 1'b0; rd = '0;
        if (v.is_d) begin
            i_dReq = 1'b1; i_dWe = v.we; i_dAddr = v.addr; i_dWData = v.wd;
        end else begin
            i_ifReq = 1'b1; i_ifAddr = v.addr;
        end
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (o_busReq) begin
                if (t_req < 0) begin
                    t_req = k; a = o_busAddr; we = o_busWe; wd = o_busWData;
                end else if (o_busAddr !== a || o_busWe !== we || o_busWData !== wd) begin
                    stable = 1'b0;
                end
            end
            if (v.is_d ? o_dValid : o_ifValid) begin
                t_resp = k; rd = v.is_d ? o_dRData : o_ifData; req_at_resp = o_busReq;
                break;
            end
        end
        i_dReq = 1'b0; i_ifReq = 1'b0;
        repeat (3) @(negedge clk);
        chk({v.name, "_grant_lat"}, t_req, 1);
        chk({v.name, "_bus_addr"}, a, v.addr);
        chk({v.name, "_bus_we"}, we, v.is_d && v.we);
        if (v.is_d && v.we) chk({v.name, "_bus_wdata"}, wd, v.wd);
        chk({v.name, "_bus_stable"}, stable, 1'b1);
        chk({v.name, "_resp_lat"}, t_resp - t_req, v.lat + 1);
        chk({v.name, "_rdata"}, rd, v.exp_rd);
        chk({v.name, "_busreq_low"}, req_at_resp, 1'b0);
        chk({v.name, "_own_pulses"}, v.is_d ? d_pulses - p_d : if_pulses - p_if, 1);
        chk({v.name, "_other_pulses"}, v.is_d ? if_pulses - p_if : d_pulses - p_d, 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        vec_t            vecs[7];
        logic [XLEN-1:0] rd, d;
        int              t_d, t_f, p_if, p_d, idx, got;

        vecs[0] = '{"load_100",  1, 0, 32'h100, 32'h0,        3, 1, 32'hDEADBEEF, 32'hDEADBEEF};
        vecs[1] = '{"store_200", 1, 1, 32'h200, 32'h12345678, 1, 0, 32'h0,        32'hDEADBEEF};
        vecs[2] = '{"fetch_40",  0, 0, 32'h40,  32'h0,        0, 1, 32'h00000013, 32'h00000013};
        vecs[3] = '{"load_200",  1, 0, 32'h200, 32'h0,        2, 0, 32'h0,        32'h12345678};
        vecs[4] = '{"fetch_44",  0, 0, 32'h44,  32'h0,        5, 1, 32'hFFFFFFFF, 32'hFFFFFFFF};
        vecs[5] = '{"store_300", 1, 1, 32'h300, 32'h0,        0, 0, 32'h0,        32'h12345678};
        vecs[6] = '{"load_300",  1, 0, 32'h300, 32'h0,        0, 1, 32'hAAAA5555, 32'h0};
        // load_300 preloads junk, but the store before it overwrites memory with 0
        vecs[6].preload = 0;

        i_rst = 1'b1; i_ifReq = 1'b0; i_ifAddr = '0; i_dReq = 1'b0; i_dWe = 1'b0;
        i_dAddr = '0; i_dWData = '0;
        repeat (2) @(negedge clk);
        chk("rst_state",  o_dbgState, ARB_IDLE);
        chk("rst_busreq", o_busReq, 1'b0);
        chk("rst_buswe",  o_busWe, 1'b0);
        chk("rst_busaddr", o_busAddr, 32'h0);
        chk("rst_buswdata", o_busWData, 32'h0);
        chk("rst_ifdata", o_ifData, 32'h0);
        chk("rst_drdata", o_dRData, 32'h0);
        chk("rst_ifvalid", o_ifValid, 1'b0);
        chk("rst_dvalid", o_dValid, 1'b0);
        i_rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // Collision: store and fetch raised together, store must go first.
        bus_mem[32'h40] = 32'h00000013;
        grant_addr_q.delete(); grant_we_q.delete(); grant_wd_q.delete();
        set_lat(1, 1);
        fork
            do_data(1'b1, 32'h200, 32'h12345678, rd, t_d);
            do_fetch(32'h40, d, t_f);
        join
        repeat (2) @(negedge clk);
        chk("coll_grants", grant_addr_q.size(), 2);
        if (grant_addr_q.size() == 2) begin
            chk("coll_first_addr", grant_addr_q[0], 32'h200);
            chk("coll_first_we", grant_we_q[0], 1'b1);
            chk("coll_first_wd", grant_wd_q[0], 32'h12345678);
            chk("coll_second_addr", grant_addr_q[1], 32'h40);
            chk("coll_second_we", grant_we_q[1], 1'b0);
        end
        chk("coll_order", t_d < t_f, 1'b1);
        chk("coll_fetch_data", d, 32'h00000013);

        // Flush: redirect 0x40 -> 0x80 while the first fetch is on the bus.
        bus_mem[32'h40] = 32'h11111111;
        bus_mem[32'h80] = 32'h22222222;
        grant_addr_q.delete(); grant_we_q.delete(); grant_wd_q.delete();
        set_lat(4, 4);
        p_if = if_pulses;
        i_ifReq = 1'b1; i_ifAddr = 32'h40;
        for (int k = 0; k < 20 && !o_busReq; k++) @(negedge clk);
        chk("flush_first_issue", o_busReq, 1'b1);
        @(negedge clk);
        i_ifAddr = 32'h80;
        got = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (o_ifValid) begin
                got = 1; d = o_ifData;
                break;
            end
        end
        i_ifReq = 1'b0;
        repeat (3) @(negedge clk);
        chk("flush_got_valid", got, 1);
        chk("flush_data", d, 32'h22222222);
        chk("flush_pulses", if_pulses - p_if, 1);
        chk("flush_grants", grant_addr_q.size(), 2);
        if (grant_addr_q.size() == 2) begin
            chk("flush_stale_addr", grant_addr_q[0], 32'h40);
            chk("flush_new_addr", grant_addr_q[1], 32'h80);
        end

        // Reset in the middle of a load, then a late ack that must be ignored.
        mem_en = 1'b0;
        bus_ack = 1'b0;
        p_d = d_pulses;
        i_dReq = 1'b1; i_dWe = 1'b0; i_dAddr = 32'h180;
        for (int k = 0; k < 20 && !o_busReq; k++) @(negedge clk);
        chk("rstmid_issue", o_busReq, 1'b1);
        @(negedge clk);
        i_rst = 1'b1; i_dReq = 1'b0;
        @(negedge clk);
        chk("rstmid_busreq", o_busReq, 1'b0);
        chk("rstmid_state", o_dbgState, ARB_IDLE);
        i_rst = 1'b0;
        @(negedge clk);
        bus_ack = 1'b1; bus_rdata = 32'hBAD0BAD0;
        @(negedge clk);
        bus_ack = 1'b0;
        repeat (3) @(negedge clk);
        chk("rstmid_no_dvalid", d_pulses - p_d, 0);
        chk("rstmid_drdata", o_dRData, 32'h0);
        chk("rstmid_idle", o_dbgState, ARB_IDLE);
        mem_en = 1'b1;
        @(negedge clk);

        // Starvation: fetch held while data is re-requested back to back.
        grant_addr_q.delete(); grant_we_q.delete(); grant_wd_q.delete();
        set_lat(0, 1);
        fork
            begin
                for (int k = 0; k < 6; k++) do_data(1'b0, 32'h1000 + 4 * k, 32'h0, rd, t_d);
            end
            do_fetch(32'h40, d, t_f);
        join
        repeat (2) @(negedge clk);
        idx = -1;
        for (int k = 0; k < grant_addr_q.size(); k++) begin
            if (idx < 0 && grant_addr_q[k] == 32'h40) idx = k;
        end
`ifdef MEM_ARB_STARVE_GUARD_EN
        chk("starve_fetch_pos", idx, STARVE_MAX);
`else
        chk("starve_fetch_pos", idx, 6);
`endif
        chk("starve_grants", grant_addr_q.size(), 7);

        // Randomized traffic: zero-wait memory, then variable latency.
        ref_mem.delete();
        set_lat(0, 0);
        exp_q.delete();
        p_if = if_pulses; p_d = d_pulses;
        mon_en = 1'b1;
        fork
            rand_data(50);
            rand_fetch(50);
        join
        repeat (5) @(negedge clk);
        mon_en = 1'b0;
        chk("rand0_leftover", exp_q.size(), 0);
        chk("rand0_d_pulses", d_pulses - p_d, 50);
        chk("rand0_if_pulses", if_pulses - p_if, 50);

        set_lat(0, 3);
        exp_q.delete();
        p_if = if_pulses; p_d = d_pulses;
        mon_en = 1'b1;
        fork
            rand_data(40);
            rand_fetch(40);
        join
        repeat (8) @(negedge clk);
        mon_en = 1'b0;
        chk("rand1_leftover", exp_q.size(), 0);
        chk("rand1_d_pulses", d_pulses - p_d, 40);
        chk("rand1_if_pulses", if_pulses - p_if, 40);

        chk("valid_exclusive", both_high, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported memory bus between the core's instruction-fetch side and its load/store side.
- Sits between the pipeline's fetch/data handshakes (ifValid/memValid style) and a unified BRAM or external memory controller.
- Serialises requests with one transaction outstanding, using data-over-fetch priority.
- Drops stale fetch responses after a pipeline flush or redirect.

Parameters:
- XLEN, 32, data and address width.
- STARVE_MAX, 4, consecutive data grants tolerated while fetch waits; used only with the optional feature.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset; one clock, synchronous, active-high.
- i_ifReq  in  1  fetch request; level, held until o_ifValid or withdrawn.
- i_ifAddr  in  XLEN  fetch address (PC).
- o_ifValid  out  1  one-cycle pulse, fetch data valid.
- o_ifData  out  XLEN  fetched instruction word.
- i_dReq  in  1  load/store request; held until o_dValid.
- i_dWe  in  1  1 = store, 0 = load.
- i_dAddr  in  XLEN  data address.
- i_dWData  in  XLEN  store data.
- o_dValid  out  1  one-cycle pulse, data transaction complete (load data valid / store done).
- o_dRData  out  XLEN  load data.
- o_busReq  out  1  memory request; held until i_busAck.
- o_busWe  out  1  memory write enable.
- o_busAddr  out  XLEN  memory address.
- o_busWData  out  XLEN  memory write data.
- i_busAck  in  1  memory completion pulse; read data valid in the same cycle.
- i_busRData  in  XLEN  memory read data.

Behaviour:
- Reset values: state IDLE; o_busReq, o_busWe, o_ifValid, o_dValid = 0; o_busAddr, o_busWData, o_ifData, o_dRData = 0; stale flag 0; starve counter 0.
- States: IDLE, IF_WAIT, D_WAIT, RESP.
- IDLE arbitration:
  - i_dReq=1 -> D_WAIT; latch i_dAddr, i_dWe, i_dWData onto o_bus*; o_busReq=1 the next cycle.
  - Else i_ifReq=1 -> IF_WAIT; latch i_ifAddr; o_busWe=0.
  - Simultaneous requests -> data wins.
  - Grant latency: request sampled at cycle N, o_busReq high at N+1.
- Bus rules:
  - o_busReq, o_busAddr, o_busWe and o_busWData are stable while o_busReq=1.
  - On the i_busAck cycle: o_busReq drops the next cycle; i_busRData is registered; go to RESP.
- RESP (one cycle):
  - Pulse o_dValid with o_dRData = registered data (stores: o_dRData unchanged), or pulse o_ifValid with o_ifData, matching the granted side.
  - Then return to IDLE. Minimum back-to-back issue spacing: ack cycle + 2.
- Fetch flush/redirect in IF_WAIT: if i_ifReq drops, or i_ifAddr differs from the latched address, set stale.
  - The bus transaction still completes; it is never abandoned.
  - In RESP, o_ifValid is suppressed when stale.
  - Stale clears on IDLE entry.
- Data side: i_dReq must not drop before o_dValid. Dropping it is a protocol violation; behaviour is undefined and flagged by an assertion.
- Response outputs o_ifValid and o_dValid are never both 1; each is high for at most one cycle per grant.
- Reset mid-transaction: o_busReq falls the cycle after i_rst and any later i_busAck is ignored. The memory side must tolerate abandoned requests.
- i_busAck outside IF_WAIT/D_WAIT is ignored.

Optional Feature:
- Macro: MEM_ARB_STARVE_GUARD_EN.
- Defined:
  - A counter saturating at STARVE_MAX increments on each data grant made while i_ifReq=1.
  - When count == STARVE_MAX and both requests are pending in IDLE, fetch is granted and the counter clears.
  - The counter also clears on any fetch grant.
- Undefined: strict data priority; the counter logic is absent.

Decomposition:
- Shared package/header (alongside types.vh): arbiter state encoding constants (ARB_IDLE, ARB_IF_WAIT, ARB_D_WAIT, ARB_RESP, 2 bits) and a grant-owner encoding (OWNER_IF, OWNER_D).
- One natural sub-module: mem_arb_starve_ctr (saturating counter plus override flag), instantiated only under the macro.
- The FSM and bus register stay in the top module.

Test Plan:
- Single load: i_dReq=1, i_dWe=0, addr 0x100; memory acks 3 cycles after o_busReq with 0xDEADBEEF -> o_busAddr=0x100, o_busWe=0; o_dValid pulses one cycle after ack with o_dRData=0xDEADBEEF; o_ifValid stays 0.
- Collision: i_ifReq (0x40) and i_dReq store (0x200, 0x12345678) in the same cycle -> store issued first with o_busWe=1, WData=0x12345678; fetch 0x40 issued after o_dValid; o_ifValid follows.
- Flush: fetch 0x40 in IF_WAIT, i_ifAddr changes to 0x80 before ack -> 0x40 completes on the bus, no o_ifValid; then 0x80 is issued and o_ifValid delivers its word.
- Reset mid-op: assert i_rst while o_busReq=1 (D_WAIT) -> next cycle o_busReq=0, state IDLE; an ack arriving afterwards produces no o_dValid.
- Starvation, with MEM_ARB_STARVE_GUARD_EN and STARVE_MAX=4: i_ifReq held, i_dReq continuously re-asserted -> exactly 4 data grants, then a fetch grant. Without the macro, fetch is never granted while i_dReq stays high.
- Zero-wait memory (ack in the first o_busReq cycle), 100 alternating requests -> every request gets exactly one response pulse, in grant order, with no lost or duplicate o_*Valid.
